muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage; successor to the single-purpose serial multiplier.
- Adds signed/unsigned divide, internal HI/LO architectural registers, configurable multiply bits-per-cycle, abort on pipeline flush, and a busy/done handshake.
- The hazard unit stalls on busy.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/muldiv_div_step.sv | 18 +
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and iteration-count helper for the iterative multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [1:0] {MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  function automatic int iter_count(int width, int mul_step, logic is_div);
    return is_div ? width : width / mul_step;
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q
);
  logic [WIDTH:0] trial, diff;

  assign trial   = {rem_in, bit_in};
  assign diff    = trial - {1'b0, divisor};
  // rem_in < divisor keeps diff below 2^WIDTH when it fits, so the top bit is a clean borrow
  assign q       = ~diff[WIDTH];
  assign rem_out = q ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO registers and flush abort.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] N_MUL = CW'(iter_count(WIDTH, MUL_STEP, 1'b0));
  localparam logic [CW-1:0] N_DIV = CW'(iter_count(WIDTH, MUL_STEP, 1'b1));

  state_e             state;
  logic               is_div, q_neg, r_neg, dz;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mc, mul_sum, prod;
  logic [WIDTH-1:0]   bm, a_orig, a_mag, b_mag, rem_nxt, quo, rem;
  logic               signed_op, a_neg, b_neg, q_bit;

  assign signed_op = (op == MULT) || (op == DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign busy      = (state != IDLE);

  // MUL_STEP partial products retired per cycle, multiplicand pre-shifted in mc
  always_comb begin
    mul_sum = acc;
    for (int j = 0; j < MUL_STEP; j++)
      if (bm[j]) mul_sum = mul_sum + (mc << j);
  end

  // Divide keeps {remainder, dividend/quotient} in acc, shifting left one bit per step
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in (acc[2*WIDTH-1:WIDTH]),
    .bit_in (acc[WIDTH-1]),
    .divisor(bm),
    .rem_out(rem_nxt),
    .q      (q_bit)
  );

  assign prod = q_neg ? -acc : acc;
  assign quo  = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mc     <= '0;
      bm     <= '0;
      a_orig <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start && !flush) begin
            is_div <= op[1];
            dz     <= (b == '0);
            a_orig <= a;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            bm     <= b_mag;
            mc     <= {{WIDTH{1'b0}}, a_mag};
            acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
            cnt    <= op[1] ? N_DIV : N_MUL;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush) state <= IDLE;
          else begin
            if (is_div) acc <= {rem_nxt, acc[WIDTH-2:0], q_bit};
            else begin
              acc <= mul_sum;
              mc  <= mc << MUL_STEP;
              bm  <= bm >> MUL_STEP;
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (dz) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one MUL_STEP=1 instance and one MUL_STEP=4 instance.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush, wr_hi, wr_lo, sel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy0, done0, busy1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic        start0, start1, busy_s, done_s;
  logic [31:0] hi_s, lo_s;
  int          n_chk = 0, n_fail = 0;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign hi_s   = sel ? hi1 : hi0;
  assign lo_s   = sel ? lo1 : lo0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

  muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble a/b to show operands are captured
  task automatic launch(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    sel = s; op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag, input int pre, input int exp_cyc,
                           input logic [31:0] eh, input logic [31:0] el);
    int cyc = pre;
    while (busy_s && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, cyc, exp_cyc);
    check({tag, " done"}, done_s, 1'b1);
    check({tag, " hi"}, hi_s, eh);
    check({tag, " lo"}, lo_s, el);
    @(negedge clk);
    check({tag, " done_pulse"}, done_s, 1'b0);
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; sel = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst hi", hi0, 0);
    check("rst lo", lo0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    rst = 1'b0;
    @(negedge clk);

    launch(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 0, 33, 32'hFFFFFFFE, 32'h00000001);
    launch(0, 2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done("mult_neg", 0, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    launch(0, 2'b00, 32'h80000000, 32'h80000000);
    wait_done("mult_min", 0, 33, 32'h40000000, 32'h00000000);
    launch(0, 2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    launch(0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_m1", 0, 33, 32'h00000000, 32'h80000000);
    launch(0, 2'b10, 32'hFFFFFFFB, 32'd0);
    wait_done("div_zero_s", 0, 33, 32'hFFFFFFFB, 32'hFFFFFFFF);
    launch(0, 2'b11, 32'd100, 32'd0);
    wait_done("divu_zero", 0, 33, 32'h00000064, 32'hFFFFFFFF);

    // start during busy must be ignored
    launch(0, 2'b11, 32'd100, 32'd7);
    op = 2'b01; a = 32'd5; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy", 1, 33, 32'd2, 32'd14);

    // reset mid-divide
    launch(0, 2'b10, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst hi", hi0, 0);
    check("midrst lo", lo0, 0);
    check("midrst busy", busy0, 0);
    check("midrst done", done0, 0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    check("midrst no_done", seen_done, 1'b0);

    // preload HI/LO, then flush a multiply mid-run
    wr_hi = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    wr_lo = 1'b0;
    check("preload hi", hi0, 32'hAAAA0000);
    check("preload lo", lo0, 32'h00000055);
    launch(0, 2'b01, 32'd3, 32'd5);
    seen_done = 1'b0;
    for (int i = 1; i < 10; i++) begin
      wr_lo = (i == 5); wdata = 32'h00001234;
      @(negedge clk);
      if (done0) seen_done = 1'b1;
    end
    wr_lo = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy0, 0);
    check("flush done", done0 | seen_done, 0);
    check("flush hi", hi0, 32'hAAAA0000);
    check("flush lo", lo0, 32'h00000055);
    @(negedge clk);
    check("flush done_late", done0, 0);
    launch(0, 2'b01, 32'd3, 32'd5);
    wait_done("after_flush", 0, 33, 32'd0, 32'd15);

    // write together with start: write lands now, result overwrites later
    wr_lo = 1'b1; wdata = 32'h00000077;
    launch(0, 2'b01, 32'd2, 32'd3);
    wr_lo = 1'b0;
    check("wr_start lo", lo0, 32'h00000077);
    wait_done("wr_start", 0, 33, 32'd0, 32'd6);

    // start and flush together in IDLE
    flush = 1'b1;
    launch(0, 2'b01, 32'd3, 32'd5);
    flush = 1'b0;
    check("sf busy0", busy0, 0);
    @(negedge clk);
    check("sf busy1", busy0, 0);
    check("sf done", done0, 0);

    // MUL_STEP=4 instance
    launch(1, 2'b01, 32'h12345678, 32'h00000010);
    wait_done("step4_mul", 0, 9, 32'h00000001, 32'h23456780);
    launch(1, 2'b11, 32'd100, 32'd7);
    wait_done("step4_div", 0, 33, 32'd2, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
